// File: rtl/dc_vlc_encoder.sv
`default_nettype none
// ============================================================================
// Module  : dc_vlc_encoder
// Purpose : Exp-Golomb coder for the per-block DC coefficients of a slice.
//           First DC at a fixed order, later DCs as sign-mapped differences.
// Revision: 1.0 - initial release
// ============================================================================
module dc_vlc_encoder #(
    parameter int DC_WIDTH = 12,
    parameter int FIRST_K  = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dc_vlc_reset,
    input  logic [31:0]         block_num,
    input  logic [DC_WIDTH-1:0] dc_coeff,
    input  logic                dc_valid,
    output logic [31:0]         vlc_code,
    output logic [5:0]          vlc_len,
    output logic                vlc_valid,
    output logic                slice_done
);
    localparam int         C_UW      = DC_WIDTH + 1;
    localparam int         C_WW      = ((C_UW > FIRST_K) ? C_UW : FIRST_K) + 1;
    localparam logic [4:0] C_FIRST_K = 5'(FIRST_K);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_DIFF  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         blk_total_q, blk_total_d;
    logic [31:0]         blk_cnt_q, blk_cnt_d;
    logic [DC_WIDTH-1:0] prev_dc_q, prev_dc_d;
    logic [C_UW-1:0]     prev_u_q, prev_u_d;

    logic                s1_valid_q, s1_valid_d;
    logic                s1_last_q, s1_last_d;
    logic [C_UW-1:0]     s1_u_q, s1_u_d;
    logic [4:0]          s1_k_q, s1_k_d;

    logic                vlc_valid_q, vlc_valid_d;
    logic                slice_done_q, slice_done_d;
    logic [31:0]         vlc_code_q, vlc_code_d;
    logic [5:0]          vlc_len_q, vlc_len_d;

    logic                   w_abort;
    logic                   w_last;
    logic signed [C_UW-1:0] w_diff;
    logic [C_UW-1:0]        w_u;
    logic [4:0]             w_k;
    logic [C_WW-1:0]        w_eg;
    logic [4:0]             w_msb;

    // -2d-1 equals ~(2d); |d| < 2^DC_WIDTH so u always fits in C_UW bits.
    always_comb begin
        w_diff = $signed({dc_coeff[DC_WIDTH-1], dc_coeff});
        if (state_q != ST_FIRST) begin
            w_diff = w_diff - $signed({prev_dc_q[DC_WIDTH-1], prev_dc_q});
        end
        w_u = w_diff[C_UW-1] ? ~{w_diff[C_UW-2:0], 1'b0} : {w_diff[C_UW-2:0], 1'b0};

        if (state_q == ST_FIRST) begin
            w_k = C_FIRST_K;
        end else if (prev_u_q == '0) begin
            w_k = 5'd0;
        end else if (prev_u_q <= C_UW'(2)) begin
            w_k = 5'd1;
        end else if (prev_u_q <= C_UW'(6)) begin
            w_k = 5'd2;
        end else begin
            w_k = 5'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        blk_total_d = blk_total_q;
        blk_cnt_d   = blk_cnt_q;
        prev_dc_d   = prev_dc_q;
        prev_u_d    = prev_u_q;
        s1_valid_d  = 1'b0;
        s1_last_d   = s1_last_q;
        s1_u_d      = s1_u_q;
        s1_k_d      = s1_k_q;
        w_abort     = 1'b0;
        w_last      = (blk_cnt_q + 32'd1) == blk_total_q;

        case (state_q)
            ST_IDLE: begin
                if (!dc_vlc_reset && (block_num != 32'd0)) begin
                    blk_total_d = block_num;
                    blk_cnt_d   = 32'd0;
                    state_d     = ST_FIRST;
                end
            end
            ST_FIRST, ST_DIFF: begin
                if (dc_vlc_reset) begin
                    w_abort = 1'b1;
                    state_d = ST_IDLE;
                end else if (dc_valid) begin
                    s1_valid_d = 1'b1;
                    s1_last_d  = w_last;
                    s1_u_d     = w_u;
                    s1_k_d     = w_k;
                    prev_dc_d  = dc_coeff;
                    prev_u_d   = w_u;
                    blk_cnt_d  = blk_cnt_q + 32'd1;
                    state_d    = w_last ? ST_IDLE : ST_DIFF;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_eg  = C_WW'(s1_u_q) + (C_WW'(1) << s1_k_q);
        w_msb = '0;
        for (int i = 0; i < C_WW; i++) begin
            if (w_eg[i]) begin
                w_msb = 5'(i);
            end
        end
    end

    // An abort kills whatever sits in stage 1 as well as the output stage.
    always_comb begin
        vlc_valid_d  = s1_valid_q && !w_abort;
        slice_done_d = s1_valid_q && s1_last_q && !w_abort;
        vlc_code_d   = vlc_code_q;
        vlc_len_d    = vlc_len_q;
        if (s1_valid_q) begin
            vlc_code_d = 32'(w_eg);
            vlc_len_d  = {w_msb, 1'b0} + 6'd1 - {1'b0, s1_k_q};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            blk_total_q  <= '0;
            blk_cnt_q    <= '0;
            prev_dc_q    <= '0;
            prev_u_q     <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_u_q       <= '0;
            s1_k_q       <= '0;
            vlc_valid_q  <= 1'b0;
            slice_done_q <= 1'b0;
            vlc_code_q   <= '0;
            vlc_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            blk_total_q  <= blk_total_d;
            blk_cnt_q    <= blk_cnt_d;
            prev_dc_q    <= prev_dc_d;
            prev_u_q     <= prev_u_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_u_q       <= s1_u_d;
            s1_k_q       <= s1_k_d;
            vlc_valid_q  <= vlc_valid_d;
            slice_done_q <= slice_done_d;
            vlc_code_q   <= vlc_code_d;
            vlc_len_q    <= vlc_len_d;
        end
    end

    assign vlc_code   = vlc_code_q;
    assign vlc_len    = vlc_len_q;
    assign vlc_valid  = vlc_valid_q;
    assign slice_done = slice_done_q;

endmodule
`default_nettype wire

// File: doc/dc_vlc_encoder.md
Name: dc_vlc_encoder

Overview:
- Entropy-codes the per-block DC coefficients of one slice into variable-length codewords.
- Sits directly downstream of the slice sequencer. Consumes its active-high `dc_vlc_reset` hold/start line and the slice `block_num`. Receives DC values from the DCT/quant stage.
- Codes the first DC with a fixed-order exp-Golomb code. Codes each later DC as a sign-mapped difference, with an adaptive exp-Golomb order.
- Codewords feed the slice bit packer.

Parameters:
- DC_WIDTH, 12, signed width of the DC coefficient input.
- FIRST_K, 5, exp-Golomb order used for the first DC of a slice.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dc_vlc_reset  in  1  from sequencer. 1 holds the block idle/aborts. Sampled 0 starts a slice.
- block_num  in  32  blocks per slice. Sampled on the start cycle.
- dc_coeff  in  DC_WIDTH  signed DC value of the current block.
- dc_valid  in  1  dc_coeff valid this cycle. No backpressure.
- vlc_code  out  32  codeword, right-aligned, unused upper bits 0.
- vlc_len  out  6  codeword length in bits (1..24 at default widths).
- vlc_valid  out  1  vlc_code/vlc_len valid this cycle.
- slice_done  out  1  one-cycle pulse with the last codeword of a slice.

Behaviour:
- Reset (async, active-high):
  - All outputs 0; state IDLE.
  - Block counter 0, prev_u 0, pipeline valids 0.
- States:
  - IDLE: on `dc_vlc_reset`==0 and `block_num`!=0, latch `block_num`, go to FIRST. If `block_num`==0, stay IDLE.
  - FIRST: `dc_valid` accepted. Code with k=FIRST_K, prev_dc<=dc_coeff, go to DIFF. If `block_num`==1, go to IDLE instead.
  - DIFF: each `dc_valid` is coded as a difference. On the latched-`block_num`-th accepted coefficient, go to IDLE.
- `dc_valid` is ignored in IDLE, including on the start cycle itself. The first coefficient is accepted from the cycle after start onward.
- `dc_vlc_reset`==1 in FIRST/DIFF:
  - Aborts immediately; next state IDLE.
  - Both pipeline valid bits cleared: any codeword in flight is dropped, and no `slice_done` is issued.
  - Abort has priority over a coincident `dc_valid`.
- Mapping. The difference d = dc_coeff - prev_dc is computed in DC_WIDTH+1 bits (the first DC uses d = dc_coeff). u = 2d for d>=0, and -2d-1 for d<0. u is DC_WIDTH+1 bits unsigned.
- Order k:
  - FIRST: k = FIRST_K.
  - DIFF, from prev_u (the u of the previously coded block): prev_u==0 -> k=0; 1..2 -> k=1; 3..6 -> k=2; >=7 -> k=3.
- Exp-Golomb coding:
  - w = u + 2^k; n = index of the MSB of w.
  - Codeword = (n-k) zeros followed by w in n+1 bits.
  - vlc_len = 2n-k+1; vlc_code = w zero-extended.
- Pipeline, latency 2:
  - Stage 1 registers u, k, and the last flag.
  - Stage 2 does the leading-one detect and registers the outputs.
  - `vlc_valid` goes high exactly 2 cycles after an accepted `dc_valid`. Back-to-back inputs give back-to-back outputs.
- `slice_done` = `vlc_valid` AND the last flag.
- prev_dc and prev_u update at acceptance, so every-cycle input is supported.
- A new start may arrive while the last two codewords of the previous slice are still draining. They complete normally.
- While `vlc_valid`=0, `vlc_code`/`vlc_len` hold their last value (don't-care).

Test Plan:
- Start with block_num=4, DC sequence 0, 3, 1, 1 on consecutive cycles -> codes (code,len): (0x20,6), (0x07,5), (0x7,3), (0x4,3). `vlc_valid` appears 2 cycles after each input; `slice_done` comes with the 4th only.
- block_num=1, DC=-1 -> a single (0x21,6) with `slice_done`=1 the same cycle; state returns to IDLE.
- Extremes: block_num=2, DC -2048 then 2047 -> (0x101F,20), then delta 4095, u=8190, k=3 -> (0x2006,24).
- `dc_vlc_reset` raised 1 cycle after the 3rd of 8 inputs -> only the first 2 codes emitted, no `slice_done`. `dc_valid` is then ignored until a new start.
- block_num=0 start, and `dc_valid` asserted while IDLE or on the start cycle -> no `vlc_valid`.
- Async `reset` mid-slice -> all outputs 0 immediately. After release, a new start with DC=0 gives k=5, code (0x20,6).
